elastic_pipe_register: RTL and testbench



---
 rtl/elastic_pipe_register_pkg.sv | 25 ++
 rtl/elastic_pipe_register_pipe_stage.sv | 43 ++++
 rtl/elastic_pipe_register.sv | 127 ++++++++++++
 tb/tb_elastic_pipe_register.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/elastic_pipe_register_pkg.sv
// elastic_pipe_register_pkg
//   Shared FPU pipeline helpers: a constant clog2 function and the width
//   formula for the elastic pipe register's OCCUPANCY output.
//   No ports (package).
package elastic_pipe_register_pkg;

    // Ceiling log2 with a floor of 1 bit, usable in parameter context.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

    // OCCUPANCY must represent 0 .. Stages+RegisteredReady inclusive.
    function automatic int unsigned occ_width(input int unsigned stages,
                                              input int unsigned registered_ready);
        return clog2(stages + registered_ready + 1);
    endfunction

endpackage

// File: rtl/elastic_pipe_register_pipe_stage.sv
// pipe_stage
//   One valid+data stage of the elastic pipe register.
//   Ports:
//     CLK        rising-edge clock
//     RST        synchronous active-high reset (valid and data cleared)
//     FLUSH      synchronous discard of the held beat (data retained)
//     load       stage takes its source this cycle
//     src_valid  valid of the source (previous stage or input)
//     src_data   payload of the source
//     valid      stage holds a beat
//     data       held payload
module pipe_stage #(
    parameter int unsigned DataSize = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                FLUSH,
    input  logic                load,
    input  logic                src_valid,
    input  logic [DataSize-1:0] src_data,
    output logic                valid,
    output logic [DataSize-1:0] data
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (FLUSH) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= src_valid;
            end
            // Payload only moves with a real beat, so a bubble never
            // overwrites the value left behind.
            if (load && src_valid) begin
                data <= src_data;
            end
        end
    end

endmodule

// File: rtl/elastic_pipe_register.sv
// elastic_pipe_register
//   Multi-stage valid/ready pipeline register with bubble collapsing,
//   synchronous flush and an optional input skid entry that makes IN_READY
//   a flop output.
//   Ports:
//     CLK        rising-edge clock
//     RST        synchronous active-high reset
//     FLUSH      synchronous discard of all held beats
//     IN_VALID   upstream beat present
//     IN_READY   block accepts a beat this cycle
//     IN_DATA    upstream payload
//     OUT_VALID  last stage holds a beat
//     OUT_READY  downstream accepts
//     OUT_DATA   last-stage payload
//     OCCUPANCY  number of beats held (stages + skid)
module elastic_pipe_register
    import elastic_pipe_register_pkg::*;
#(
    parameter int unsigned DataSize        = 32,
    parameter int unsigned Stages          = 2,
    parameter int unsigned RegisteredReady = 0
) (
    input  logic                                           CLK,
    input  logic                                           RST,
    input  logic                                           FLUSH,
    input  logic                                           IN_VALID,
    output logic                                           IN_READY,
    input  logic [DataSize-1:0]                            IN_DATA,
    output logic                                           OUT_VALID,
    input  logic                                           OUT_READY,
    output logic [DataSize-1:0]                            OUT_DATA,
    output logic [occ_width(Stages, RegisteredReady)-1:0]  OCCUPANCY
);

    localparam int unsigned OccW = occ_width(Stages, RegisteredReady);

    logic [Stages-1:0]   v;
    logic [DataSize-1:0] d [Stages];
    logic [Stages-1:0]   adv;
    logic                s0_valid;
    logic [DataSize-1:0] s0_data;
    logic                in_fire;
    logic                out_fire;
    logic [OccW-1:0]     occ;

    // adv[i] = !v[i] | adv[i+1] unrolled: stage i can move unless it and
    // every stage after it are full while the output is stalled. Writing
    // it flat keeps the chain free of self-referencing vector bits.
    for (genvar i = 0; i < Stages; i++) begin : g_adv
        assign adv[i] = OUT_READY | ~(&v[Stages-1:i]);
    end

    assign in_fire   = IN_VALID & IN_READY;
    assign OUT_VALID = v[Stages-1] & ~FLUSH;
    assign OUT_DATA  = d[Stages-1];
    assign out_fire  = OUT_VALID & OUT_READY;

    if (RegisteredReady != 0) begin : g_skid
        logic                sv;
        logic [DataSize-1:0] sd;

        always_ff @(posedge CLK) begin
            if (RST) begin
                sv <= 1'b0;
                sd <= '0;
            end else if (FLUSH) begin
                sv <= 1'b0;
            end else if (sv) begin
                if (adv[0]) begin
                    sv <= 1'b0;
                end
            end else if (in_fire && !adv[0]) begin
                sv <= 1'b1;
                sd <= IN_DATA;
            end
        end

        assign IN_READY = ~sv & ~FLUSH;
        // The skid beat is older than anything on the input, so it wins.
        assign s0_valid = sv | in_fire;
        assign s0_data  = sv ? sd : IN_DATA;
    end else begin : g_noskid
        assign IN_READY = adv[0] & ~FLUSH;
        assign s0_valid = in_fire;
        assign s0_data  = IN_DATA;
    end

    for (genvar i = 0; i < Stages; i++) begin : g_stage
        logic                src_valid;
        logic [DataSize-1:0] src_data;

        if (i == 0) begin : g_first
            assign src_valid = s0_valid;
            assign src_data  = s0_data;
        end else begin : g_chain
            assign src_valid = v[i-1];
            assign src_data  = d[i-1];
        end

        pipe_stage #(
            .DataSize(DataSize)
        ) u_stage (
            .CLK       (CLK),
            .RST       (RST),
            .FLUSH     (FLUSH),
            .load      (adv[i]),
            .src_valid (src_valid),
            .src_data  (src_data),
            .valid     (v[i]),
            .data      (d[i])
        );
    end

    // Tracked from the handshakes rather than summing the valid flops; every
    // beat enters through in_fire and leaves through out_fire, RST or FLUSH,
    // so the count always equals popcount(v) + sv.
    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            occ <= '0;
        end else begin
            occ <= occ + OccW'(in_fire) - OccW'(out_fire);
        end
    end

    assign OCCUPANCY = occ;

endmodule

// File: tb/tb_elastic_pipe_register.sv
module tb_elastic_pipe_register;

    logic CLK;
    logic RST;
    logic FLUSH;
    logic IN_VALID;
    logic [7:0] IN_DATA;
    logic OUT_READY;

    logic [2:0]      ir;
    logic [2:0]      ov;
    logic [2:0][7:0] od;
    logic [2:0][1:0] occ;

    int checks = 0;
    int errors = 0;

    // Configurations under test: u0 Stages=2/RR=0, u1 Stages=3/RR=0, u2 Stages=2/RR=1
    int S_of  [3] = '{2, 3, 2};
    int RR_of [3] = '{0, 0, 1};

    // Reference model: ordered list of held beats (oldest first) with the
    // stage index each one currently sits in, plus an optional skid beat.
    int       cnt [3];
    int       pos [3][4];
    logic [7:0] dat [3][4];
    bit       sk  [3];
    logic [7:0] skd [3];
    bit       started = 0;

    elastic_pipe_register #(.DataSize(8), .Stages(2), .RegisteredReady(0)) u0 (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(ir[0]),
        .IN_DATA(IN_DATA), .OUT_VALID(ov[0]), .OUT_READY(OUT_READY),
        .OUT_DATA(od[0]), .OCCUPANCY(occ[0]));

    elastic_pipe_register #(.DataSize(8), .Stages(3), .RegisteredReady(0)) u1 (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(ir[1]),
        .IN_DATA(IN_DATA), .OUT_VALID(ov[1]), .OUT_READY(OUT_READY),
        .OUT_DATA(od[1]), .OCCUPANCY(occ[1]));

    elastic_pipe_register #(.DataSize(8), .Stages(2), .RegisteredReady(1)) u2 (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(ir[2]),
        .IN_DATA(IN_DATA), .OUT_VALID(ov[2]), .OUT_READY(OUT_READY),
        .OUT_DATA(od[2]), .OCCUPANCY(occ[2]));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model just
    // before the edge, then advance the model across the edge.
    task automatic cyc(input logic r, input logic f, input logic iv,
                       input logic [7:0] id, input logic ordy);
        bit eir [3];
        bit eov [3];
        bit ifire, ofire, adv0;
        int lim;
        RST = r; FLUSH = f; IN_VALID = iv; IN_DATA = id; OUT_READY = ordy;
        #1;
        for (int u = 0; u < 3; u++) begin
            if (RR_of[u] != 0) eir[u] = !sk[u] && !f;
            else               eir[u] = ((cnt[u] < S_of[u]) || ordy) && !f;
            eov[u] = (cnt[u] > 0) && (pos[u][0] == S_of[u] - 1) && !f;
            if (started) begin
                check($sformatf("u%0d in_ready", u), 32'(ir[u]), 32'(eir[u]));
                check($sformatf("u%0d out_valid", u), 32'(ov[u]), 32'(eov[u]));
                if (eov[u]) check($sformatf("u%0d out_data", u), 32'(od[u]), 32'(dat[u][0]));
                check($sformatf("u%0d occupancy", u), 32'(occ[u]), 32'(cnt[u] + int'(sk[u])));
            end
        end
        @(posedge CLK);
        for (int u = 0; u < 3; u++) begin
            if (r || f) begin
                cnt[u] = 0;
                sk[u]  = 0;
            end else begin
                ifire = iv && eir[u];
                ofire = eov[u] && ordy;
                adv0  = (cnt[u] < S_of[u]) || ordy;
                if (ofire) begin
                    for (int k = 0; k < cnt[u] - 1; k++) begin
                        pos[u][k] = pos[u][k+1];
                        dat[u][k] = dat[u][k+1];
                    end
                    cnt[u]--;
                end
                for (int k = 0; k < cnt[u]; k++) begin
                    lim = (k == 0) ? S_of[u] - 1 : pos[u][k-1] - 1;
                    pos[u][k] = (pos[u][k] + 1 < lim) ? pos[u][k] + 1 : lim;
                end
                if (sk[u] && adv0) begin
                    pos[u][cnt[u]] = 0; dat[u][cnt[u]] = skd[u]; cnt[u]++;
                    sk[u] = 0;
                end else if (ifire && adv0) begin
                    pos[u][cnt[u]] = 0; dat[u][cnt[u]] = id; cnt[u]++;
                end else if (ifire) begin
                    sk[u] = 1; skd[u] = id;
                end
            end
        end
        started = 1;
        @(negedge CLK);
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            cnt[u] = 0; sk[u] = 0; skd[u] = '0;
        end
        RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b1; IN_DATA = 8'hFF; OUT_READY = 1'b0;
        @(negedge CLK);

        // Reset for two cycles with IN_VALID high
        cyc(1, 0, 1, 8'hFF, 0);
        cyc(1, 0, 1, 8'hFF, 0);
        RST = 1'b0; IN_VALID = 1'b0;
        #1;
        for (int u = 0; u < 3; u++) begin
            check($sformatf("u%0d reset out_valid", u), 32'(ov[u]), 32'd0);
            check($sformatf("u%0d reset out_data", u), 32'(od[u]), 32'd0);
            check($sformatf("u%0d reset occupancy", u), 32'(occ[u]), 32'd0);
            check($sformatf("u%0d ready after reset", u), 32'(ir[u]), 32'd1);
        end

        // Streaming, back-to-back
        cyc(0, 0, 1, 8'h01, 1);
        cyc(0, 0, 1, 8'h02, 1);
        cyc(0, 0, 1, 8'h03, 1);
        repeat (5) cyc(0, 0, 0, 8'h00, 1);

        // Back-pressure
        cyc(0, 0, 1, 8'h0A, 0);
        cyc(0, 0, 1, 8'h0B, 0);
        cyc(0, 0, 1, 8'h0C, 0);
        cyc(0, 0, 1, 8'h0C, 0);
        check("u0 full in_ready", 32'(ir[0]), 32'd0);
        check("u0 full occupancy", 32'(occ[0]), 32'd2);
        check("u0 full head", 32'(od[0]), 32'h0A);
        cyc(0, 0, 1, 8'h0C, 1);
        repeat (6) cyc(0, 0, 0, 8'h00, 1);

        // Bubble collapse
        cyc(0, 0, 1, 8'h05, 0);
        cyc(0, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 8'h00, 0);
        cyc(0, 0, 1, 8'h06, 0);
        cyc(0, 0, 0, 8'h00, 0);
        check("u0 bubble occupancy", 32'(occ[0]), 32'd2);
        check("u0 bubble head", 32'(od[0]), 32'h05);
        repeat (6) cyc(0, 0, 0, 8'h00, 1);

        // Skid entry
        cyc(0, 0, 1, 8'h11, 0);
        cyc(0, 0, 1, 8'h22, 0);
        cyc(0, 0, 1, 8'h33, 0);
        cyc(0, 0, 0, 8'h00, 0);
        check("u2 skid in_ready", 32'(ir[2]), 32'd0);
        check("u2 skid occupancy", 32'(occ[2]), 32'd3);
        repeat (6) cyc(0, 0, 0, 8'h00, 1);

        // Flush with beats held and an offered beat
        cyc(0, 0, 1, 8'h41, 0);
        cyc(0, 0, 1, 8'h42, 0);
        cyc(0, 1, 1, 8'h07, 0);
        for (int u = 0; u < 3; u++) begin
            check($sformatf("u%0d flush occupancy", u), 32'(occ[u]), 32'd0);
            check($sformatf("u%0d flush out_valid", u), 32'(ov[u]), 32'd0);
        end
        repeat (5) cyc(0, 0, 0, 8'h00, 1);

        // Randomized traffic with occasional reset and flush
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
                1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 9) < 6));
        end
        repeat (6) cyc(0, 0, 0, 8'h00, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
